// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequencer and HI/LO register bank for the multicycle divider and
// multiplier. A request in IDLE fires a one-cycle start pulse at the selected
// unit, counts that unit's fixed latency, captures its hi/lo words into the
// architectural HI/LO registers and pulses done. A zero divisor seen on the
// divider's flag two edges after the start aborts the divide, sets a sticky
// exception and pulses a local reset so the divider returns to idle.
//
// Ports:
//   clock, reset               clock and synchronous active-high reset
//   div_start, mult_start      operation requests, sampled only in IDLE
//   div_hi_in, div_lo_in       divider remainder / quotient
//   div0_in                    divider zero-divisor flag
//   mult_hi_in, mult_lo_in     multiplier upper / lower product words
//   mthi, mtlo, wr_data        direct writes into HI / LO while idle
//   DIVcontrol, MULTcontrol    one-cycle start pulses to the units
//   unit_rst                   one-cycle reset pulse to the divider
//   hi, lo                     architectural HI / LO registers
//   busy                       high whenever an operation is in flight
//   done                       one-cycle completion (or abort) pulse
//   div0_exc                   sticky divide-by-zero exception
module hilo_ctrl #(
  parameter int DIV_LATENCY  = 34,
  parameter int MULT_LATENCY = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_start,
  input  logic        mult_start,
  input  logic [31:0] div_hi_in,
  input  logic [31:0] div_lo_in,
  input  logic        div0_in,
  input  logic [31:0] mult_hi_in,
  input  logic [31:0] mult_lo_in,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic        DIVcontrol,
  output logic        MULTcontrol,
  output logic        unit_rst,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    MULT_RUN = 2'd2
  } state_t;

  localparam logic [5:0] DIV_LAT  = 6'(DIV_LATENCY);
  localparam logic [5:0] MULT_LAT = 6'(MULT_LATENCY);

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        divc_nxt, multc_nxt, urst_nxt, busy_nxt, done_nxt, exc_nxt;

  // State and output registers; every output is driven from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 6'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      DIVcontrol  <= 1'b0;
      MULTcontrol <= 1'b0;
      unit_rst    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div0_exc    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi          <= hi_nxt;
      lo          <= lo_nxt;
      DIVcontrol  <= divc_nxt;
      MULTcontrol <= multc_nxt;
      unit_rst    <= urst_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div0_exc    <= exc_nxt;
    end
  end

  // Next-state and next-output logic. Pulses (start, unit_rst, done) default
  // to 0 so each is high for exactly the cycle after the edge that raised it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    divc_nxt  = 1'b0;
    multc_nxt = 1'b0;
    urst_nxt  = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    exc_nxt   = div0_exc;

    unique case (state)
      IDLE: begin
        // A start takes precedence over a same-edge mthi/mtlo, which is dropped.
        if (div_start) begin
          divc_nxt  = 1'b1;
          cnt_nxt   = 6'd0;
          exc_nxt   = 1'b0;
          state_nxt = DIV_RUN;
          busy_nxt  = 1'b1;
        end else if (mult_start) begin
          multc_nxt = 1'b1;
          cnt_nxt   = 6'd0;
          exc_nxt   = 1'b0;
          state_nxt = MULT_RUN;
          busy_nxt  = 1'b1;
        end else begin
          if (mthi) hi_nxt = wr_data;
          if (mtlo) lo_nxt = wr_data;
        end
      end

      DIV_RUN: begin
        cnt_nxt = cnt + 6'd1;
        // The divider flags a zero divisor only in this one window; the flag
        // is meaningless at any other count.
        if (cnt == 6'd1 && div0_in) begin
          exc_nxt   = 1'b1;
          urst_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else if (cnt == DIV_LAT) begin
          hi_nxt    = div_hi_in;
          lo_nxt    = div_lo_in;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end

      MULT_RUN: begin
        cnt_nxt = cnt + 6'd1;
        if (cnt == MULT_LAT) begin
          hi_nxt    = mult_hi_in;
          lo_nxt    = mult_lo_in;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
